exti_edge_controller: RTL
=========================

// Module: exti_edge_controller
// PURPOSE
//   Parametrised, clocked external-interrupt front end for the NVIC. Per line: synchroniser,
//   glitch filter, registered rising/falling edge detect, software trigger, pending latch
//   with write-1-to-clear, masked IRQ level and event pulse. Sits between pads and NVIC inputs.
// PARAMETERS
//   NUM_LINES    21  number of external lines
//   SYNC_STAGES  2   flops in input synchroniser (legal >=2)
//   FILTER_LEN   3   consecutive equal samples needed to accept a new level (0 = bypass)
// PORTS
//   clk          in   1          single clock, all logic rising-edge
//   rst          in   1          asynchronous, active-high reset
//   signal_line  in   NUM_LINES  raw external lines, asynchronous to clk
//   EXTI_RTSR    in   NUM_LINES  rising-edge trigger enable
//   EXTI_FTSR    in   NUM_LINES  falling-edge trigger enable
//   EXTI_IMR     in   NUM_LINES  interrupt mask (1 = enabled)
//   EXTI_EMR     in   NUM_LINES  event mask (1 = enabled)
//   EXTI_SWIER   in   NUM_LINES  software trigger, 1-cycle pulse per bit
//   pr_clr       in   NUM_LINES  pending clear, 1-cycle pulse per bit (W1C)
//   EXTI_PR      out  NUM_LINES  pending register
//   irq          out  NUM_LINES  interrupt request level to NVIC (= EXTI_PR)
//   evt          out  NUM_LINES  event pulse, 1 cycle
//   EDGE_DETECTED out NUM_LINES  qualified edge strobe, 1 cycle (debug/observe)
// BEHAVIOUR
//   - Reset: sync chain, filtered level, previous level, filter counters, EXTI_PR, irq, evt,
//     EDGE_DETECTED all 0. Reset mid-operation discards in-flight edges and pending bits.
//   - Sync: signal_line -> SYNC_STAGES flops -> s[i].
//   - Filter (FILTER_LEN>0): cnt[i] clears when s[i]==lvl[i]; else increments; when cnt reaches
//     FILTER_LEN-1 while s[i]!=lvl[i], lvl[i]<=s[i], cnt<=0. Pulse shorter than FILTER_LEN
//     samples never changes lvl. FILTER_LEN=0: lvl[i]=s[i] registered, no counter.
//     Counter width $clog2(FILTER_LEN+1); never wraps (saturates by construction).
//   - Edge: prev[i]<=lvl[i] each cycle; rise=lvl&~prev, fall=~lvl&prev.
//     trig = (rise&RTSR)|(fall&FTSR)|SWIER. EDGE_DETECTED<=trig (registered).
//   - Latency: stable input change to EDGE_DETECTED high = SYNC_STAGES+FILTER_LEN+1 cycles.
//   - Line high through reset release yields one rising edge once filtered (intentional).
//   - RTSR and FTSR both set: both edges trigger. Trigger-enable change takes effect on the
//     next edge only; no retroactive trigger.
//   - Pending: EXTI_PR[i] <= (EXTI_PR[i] & ~pr_clr[i]) | (trig[i] & IMR[i]); set wins
//     over simultaneous clear. Further triggers while pending are merged (no count).
//   - Clearing IMR does not clear EXTI_PR; irq = EXTI_PR.
//   - evt[i] <= trig[i] & EMR[i]; same cycle as EDGE_DETECTED, independent of EXTI_PR.
//   - SWIER bypasses sync/filter: enters trig directly, EDGE_DETECTED 1 cycle later.
// STRUCTURE
//   - exti_pkg: EXTI_NUM_LINES_DFLT=21, SYNC_STAGES_DFLT=2, FILTER_LEN_DFLT=3.
//   - Sub-module exti_line_filter (one line: sync chain + counter + lvl), generated
//     NUM_LINES times; top holds edge, pending, event logic as vectors.
// TESTING
//   - Reset: rst=1 with lines toggling -> all outputs 0; release with lines 0 -> no activity.
//   - Rise: RTSR[0]=1, IMR[0]=1, line0 0->1 held -> EDGE_DETECTED[0] pulse at cycle 6
//     (2+3+1), EXTI_PR[0]=1 next cycle, stays 1 until pr_clr[0] pulse, then 0.
//   - Glitch: line3 high for 2 cycles, FTSR/RTSR[3]=1 -> no edge, no PR; 3-cycle pulse -> rise
//     and later fall both detected.
//   - Masks: IMR[5]=0, EMR[5]=1, falling edge -> evt[5] 1-cycle pulse, EXTI_PR[5] stays 0.
//   - Collision: pr_clr[7] and trig[7] same cycle -> EXTI_PR[7] remains 1.
//   - SWIER: SWIER[20] pulse, IMR[20]=1 -> EDGE_DETECTED[20] next cycle, irq[20]=1 after;
//     rst asserted mid-pending -> irq[20]=0 immediately.

Source files
------------

// File: rtl/exti_pkg.sv
// Shared defaults and helpers for the external-interrupt edge controller.
package exti_pkg;
    localparam int EXTI_NUM_LINES_DFLT = 21;
    localparam int SYNC_STAGES_DFLT    = 2;
    localparam int FILTER_LEN_DFLT     = 3;

    // Width of the glitch-filter counter; at least 1 bit so a zero-width vector never appears.
    function automatic int filter_cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction
endpackage

// File: rtl/exti_line_filter.sv
// One external line: input synchroniser followed by a consecutive-sample glitch filter.
module exti_line_filter
    import exti_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
    parameter int FILTER_LEN  = FILTER_LEN_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], din};
    end

    assign s = sync[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            always_ff @(posedge clk or posedge rst) begin
                if (rst) lvl <= 1'b0;
                else     lvl <= s;
            end
        end else begin : g_filter
            localparam int             CW       = filter_cnt_width(FILTER_LEN);
            localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);
            logic [CW-1:0] cnt;

            // cnt tracks how many consecutive samples have disagreed with lvl; the
            // FILTER_LEN-th disagreeing sample commits the new level, so cnt never wraps.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                end else if (s == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/exti_edge_controller.sv
// External-interrupt front end: per-line filtering, edge qualification, software trigger,
// W1C pending latch, IRQ level and event pulse.
module exti_edge_controller
    import exti_pkg::*;
#(
    parameter int NUM_LINES   = EXTI_NUM_LINES_DFLT,
    parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
    parameter int FILTER_LEN  = FILTER_LEN_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LINES-1:0] signal_line,
    input  logic [NUM_LINES-1:0] EXTI_RTSR,
    input  logic [NUM_LINES-1:0] EXTI_FTSR,
    input  logic [NUM_LINES-1:0] EXTI_IMR,
    input  logic [NUM_LINES-1:0] EXTI_EMR,
    input  logic [NUM_LINES-1:0] EXTI_SWIER,
    input  logic [NUM_LINES-1:0] pr_clr,
    output logic [NUM_LINES-1:0] EXTI_PR,
    output logic [NUM_LINES-1:0] irq,
    output logic [NUM_LINES-1:0] evt,
    output logic [NUM_LINES-1:0] EDGE_DETECTED
);
    logic [NUM_LINES-1:0] lvl;
    logic [NUM_LINES-1:0] prev;
    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] fall;
    logic [NUM_LINES-1:0] trig;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        exti_line_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_filter (
            .clk(clk),
            .rst(rst),
            .din(signal_line[i]),
            .lvl(lvl[i])
        );
    end

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;
    // Software trigger skips sync/filter so firmware sees its effect one cycle later.
    assign trig = (rise & EXTI_RTSR) | (fall & EXTI_FTSR) | EXTI_SWIER;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev          <= '0;
            EXTI_PR       <= '0;
            evt           <= '0;
            EDGE_DETECTED <= '0;
        end else begin
            prev          <= lvl;
            // A new trigger wins over a clear arriving in the same cycle.
            EXTI_PR       <= (EXTI_PR & ~pr_clr) | (trig & EXTI_IMR);
            evt           <= trig & EXTI_EMR;
            EDGE_DETECTED <= trig;
        end
    end

    assign irq = EXTI_PR;
endmodule
